// File: rtl/ofm_writeback.sv
// ofm_writeback
//   Takes result groups (LANES signed elements, one per kernel, for one output
//   pixel) from the convolution datapath and buffers them in a small FIFO. It
//   then writes them one element at a time into the output feature-map memory
//   in channel-planar layout: addr = BASE_ADDR + k*ROWS*COLS + row*COLS + col.
//   done pulses for one cycle after the last element of a ROWS*COLS frame.
//
//   Optional build macro: OFM_RELU_EN. When it is defined, the serializer
//   clamps negative elements to zero. Timing and addresses do not change.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   start        begins a frame; only sampled while idle
//   in_valid     a group is offered on in_data
//   in_data      lane k = in_data[k*DW +: DW]
//   in_ready     a group is accepted when in_valid & in_ready
//   mem_we       write request (registered; held with addr/data until accepted)
//   mem_addr     write address
//   mem_wdata    write data
//   mem_ready    the memory accepts a write when mem_we & mem_ready
//   busy         high while a frame is running
//   done         one-cycle pulse at frame end
module ofm_writeback #(
    parameter int unsigned DW         = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned COLS       = 13,
    parameter int unsigned ROWS       = 13,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned GW     = LANES * DW;
    localparam int unsigned PLANE  = ROWS * COLS;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned GRP_W  = $clog2(PLANE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [GW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [GRP_W-1:0]    pushed;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [LANE_W-1:0]   lane;
    logic [GW-1:0]       ser_group;
    logic [DW-1:0]       ser_lane [LANES];

    logic                push_c;
    logic                accept_c;
    logic                last_lane_c;
    logic                grp_end_c;
    logic                frame_end_c;
    logic                pop_c;
    logic [LANE_W-1:0]   lane_inc;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [GRP_W-1:0]    pushed_nxt;
    logic [ROW_W-1:0]    row_nxt;
    logic [COL_W-1:0]    col_nxt;
    logic                in_ready_nxt;

    // Channel-planar address, formed wide and then truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [LANE_W-1:0] k,
                                                  input logic [ROW_W-1:0]  r,
                                                  input logic [COL_W-1:0]  c);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(k) * 32'(PLANE) + 32'(r) * 32'(COLS) + 32'(c);
        return a[ADDR_W-1:0];
    endfunction

    // Element conditioning applied just before the element reaches mem_wdata.
    function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
`ifdef OFM_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Lane view of the group held in the serializer.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ser_lane[i] = ser_group[i*DW +: DW];
        end
    end

    // Handshakes and serializer sequencing.
    always_comb begin
        push_c      = in_valid & in_ready;
        accept_c    = mem_we & mem_ready;
        last_lane_c = (lane == LANE_W'(LANES - 1));
        grp_end_c   = accept_c & last_lane_c;
        frame_end_c = grp_end_c & (row == ROW_W'(ROWS - 1)) & (col == COL_W'(COLS - 1));
        // The next group loads on the same edge as the last lane of the previous
        // one is accepted, which keeps writes back-to-back.
        pop_c       = (state == S_RUN) & (fifo_cnt != '0) & (~mem_we | grp_end_c);
        lane_inc    = lane + LANE_W'(1);
        cnt_nxt     = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
        pushed_nxt  = frame_end_c ? '0 : pushed + GRP_W'(push_c);
    end

    // Pixel position of the group being serialized; it moves once that group's last lane is accepted.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (grp_end_c) begin
            if (col == COL_W'(COLS - 1)) begin
                col_nxt = '0;
                row_nxt = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col_nxt = col + COL_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and next value of the registered in_ready.
    always_comb begin
        state_nxt    = state;
        in_ready_nxt = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (frame_end_c) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        in_ready_nxt = (state_nxt == S_RUN) && (cnt_nxt != CNT_W'(FIFO_DEPTH))
                       && (pushed_nxt < GRP_W'(PLANE));
    end

    // Group storage; the pointers and count below decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO control, frame counters, serializer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            pushed    <= '0;
            row       <= '0;
            col       <= '0;
            lane      <= '0;
            ser_group <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= cnt_nxt;
            pushed   <= pushed_nxt;
            row      <= row_nxt;
            col      <= col_nxt;

            if (pop_c) begin
                ser_group <= fifo_mem[rd_ptr];
                lane      <= '0;
                mem_we    <= 1'b1;
                mem_addr  <= addr_of('0, row_nxt, col_nxt);
                mem_wdata <= shape(fifo_mem[rd_ptr][DW-1:0]);
            end else if (accept_c) begin
                if (last_lane_c) begin
                    mem_we <= 1'b0;
                end else begin
                    lane      <= lane_inc;
                    mem_addr  <= addr_of(lane_inc, row, col);
                    mem_wdata <= shape(ser_lane[lane_inc]);
                end
            end

            in_ready <= in_ready_nxt;
            busy     <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback
//   Directed bench for ofm_writeback. The model turns every accepted group
//   into its LANES expected writes: element k of the g-th group in a frame goes
//   to BASE_ADDR + k*ROWS*COLS + g. The compare process checks each accepted
//   write, address/data hold during stalls, and the done pulse against the model.
module tb_ofm_writeback;

    localparam int unsigned DW         = 16;
    localparam int unsigned LANES      = 4;
    localparam int unsigned COLS       = 13;
    localparam int unsigned ROWS       = 13;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BASE_ADDR  = 0;
    localparam int unsigned GW         = LANES * DW;
    localparam int unsigned NGRP       = ROWS * COLS;
    localparam int unsigned NWR        = NGRP * LANES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [GW-1:0]     in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;

    ofm_writeback #(
        .DW(DW), .LANES(LANES), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    wr_t               exp_q[$];
    wr_t               e_tmp;
    int                m_push;
    int                m_wr;
    int                dut_wr;
    logic              done_due;
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [DW-1:0]     prev_data;
    logic              pattern_mode;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] elem_model(input logic [DW-1:0] v);
`ifdef OFM_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Model and compare process.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_push     = 0;
            m_wr       = 0;
            done_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_timing", done, done_due);
            done_due = 1'b0;
            if (in_valid && in_ready) begin
                chk("push_within_frame", (m_push < NGRP), 1);
                for (int k = 0; k < LANES; k++) begin
                    e_tmp.addr = ADDR_W'(BASE_ADDR + k * NGRP + m_push);
                    e_tmp.data = elem_model(in_data[k*DW +: DW]);
                    exp_q.push_back(e_tmp);
                end
                m_push++;
            end
            if (prev_stall) begin
                chk("stall_we", mem_we, 1);
                chk("stall_addr", mem_addr, prev_addr);
                chk("stall_data", mem_wdata, prev_data);
            end
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", mem_we, 0);
                end else begin
                    e_tmp = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e_tmp.addr);
                    chk("wr_data", mem_wdata, e_tmp.data);
                end
                if (pattern_mode && mem_wdata == 16'h2130) begin
                    chk("addr_k2_r1_c3", mem_addr, 354);
                end
                dut_wr++;
                m_wr++;
                if (m_wr == NWR) begin
                    done_due = 1'b1;
                    m_wr     = 0;
                    m_push   = 0;
                end
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [GW-1:0] rand_group();
        return GW'({$urandom(), $urandom()});
    endfunction

    task automatic push_group(input logic [GW-1:0] d);
        logic acc;
        int   n;
        acc      = 1'b0;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("push_accepted", acc, 1);
    endtask

    // Returns at a falling edge once mem_we equals val (bounded).
    task automatic wait_we(input string nm, input logic val);
        int n;
        n = 0;
        @(negedge clk);
        while (mem_we !== val && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, mem_we, val);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        logic [GW-1:0] d;
        int            acc;

        rst_n        = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        mem_ready    = 1'b1;
        pattern_mode = 1'b0;
        dut_wr       = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // in_valid while idle is ignored.
        in_valid = 1'b1;
        in_data  = rand_group();
        repeat (4) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_we", mem_we, 0);
        end
        tick();
        in_valid = 1'b0;

        // Frame A: latency, ignored start, stall, FIFO full, clamp check.
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 1);
        tick();
        push_group(rand_group());
        @(negedge clk);
        chk("latency_t1_we", mem_we, 0);
        @(negedge clk);
        chk("latency_t2_we", mem_we, 1);

        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_in_run_busy", busy, 1);
        chk("start_in_run_done", done, 0);

        wait_we("drain0", 1'b0);
        tick();
        mem_ready = 1'b0;
        push_group(rand_group());
        wait_we("stall_we_seen", 1'b1);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_lane1_addr", mem_addr, 170);
        end
        tick();
        mem_ready = 1'b1;

        wait_we("drain1", 1'b0);
        tick();
        mem_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        repeat (12) begin
            in_data = rand_group();
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("full_accepts", acc, 5);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_we_held", mem_we, 1);
        tick();
        mem_ready = 1'b1;

        wait_we("drain2", 1'b0);
        tick();
        push_group({LANES{16'hFFF6}});
        wait_we("neg_we", 1'b1);
`ifdef OFM_RELU_EN
        chk("neg_lane_wdata", mem_wdata, 16'h0000);
`else
        chk("neg_lane_wdata", mem_wdata, 16'hFFF6);
`endif
        tick();
        while (m_push < NGRP) push_group(rand_group());
        wait_done("frameA_done");
        @(negedge clk);
        chk("frameA_idle_busy", busy, 0);

        // Frame B: full frame, pattern {k,row,col}, continuous mem_ready.
        tick();
        pattern_mode = 1'b1;
        dut_wr       = 0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            for (int k = 0; k < LANES; k++) begin
                d[k*DW +: DW] = {4'(k), 4'(g / COLS), 4'(g % COLS), 4'h0};
            end
            push_group(d);
        end
        wait_done("frameB_done");
        chk("frameB_writes", dut_wr, NWR);
        pattern_mode = 1'b0;

        // Reset in the middle of a pending write.
        tick();
        start = 1'b1;
        tick();
        start     = 1'b0;
        mem_ready = 1'b0;
        push_group(rand_group());
        wait_we("abort_we_seen", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_in_ready", in_ready, 0);
            chk("post_abort_busy", busy, 0);
            chk("post_abort_we", mem_we, 0);
        end
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
